// File: rtl/sev_pkg.sv
// Shared 7-segment glyph set, BCD marker codes and the frame-reader state type.
package sev_pkg;

  // Active-high segment patterns, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Nibble codes for glyphs that are not decimal digits.
  localparam logic [3:0] BCD_BLANK = 4'hA;
  localparam logic [3:0] BCD_BAD   = 4'hF;

  // Frame reader: SYNC waits for the leftmost digit, SCAN collects the rest.
  typedef enum logic {
    SYNC = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Forward encoder used by the BCD-to-7-segment driver; anything that is
  // not a decimal digit is shown blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevtobcd_dec.sv
// Strict glyph decoder: 7 segment lines back to a BCD nibble plus blank/bad flags.
module sevtobcd_dec
  import sev_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_blank,
  output logic       o_bad
);

  // Exact-match lookup; any pattern outside the glyph set is reported bad.
  always_comb begin
    o_bcd   = BCD_BAD;
    o_blank = 1'b0;
    o_bad   = 1'b0;
    case (i_seg)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: begin
        o_bcd   = BCD_BLANK;
        o_blank = 1'b1;
      end
      default:   o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevtobcd_scan.sv
// Multiplexed 7-segment bus reader: settles each digit, decodes it and
// assembles NUM_DIGITS nibbles into a frame offered on a valid/ready port.
//
// Handshake: frame_valid/bcd_out stay stable while frame_valid && !frame_ready;
// the frame is consumed on any cycle with frame_valid && frame_ready, and a
// new frame may load on that same edge (frame_valid then stays high).
module sevtobcd_scan
  import sev_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    frame_ready,
  input  logic                    err_clr,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    err,
  output logic                    overrun,
  output logic                    dbg_state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(STABLE_CYCLES - 1);

  scan_state_t r_state, w_state_next;

  logic [6+NUM_DIGITS:0]   r_prev;
  logic [CW-1:0]           r_cnt;
  logic [NUM_DIGITS-1:0]   r_got, w_got_next;
  logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_next;
  logic                    r_frame_valid;
  logic [4*NUM_DIGITS-1:0] r_bcd_out;
  logic                    r_err;
  logic                    r_overrun;

  logic [3:0] w_bcd;
  logic       w_blank, w_bad;
  logic       w_same, w_accept, w_onehot, w_multi, w_cap;
  logic       w_complete, w_out_free, w_load;
  logic       w_err_set, w_ovr_set;

  sevtobcd_dec u_dec (
    .i_seg   (seg_in),
    .o_bcd   (w_bcd),
    .o_blank (w_blank),
    .o_bad   (w_bad)
  );

  // A sample is accepted exactly once: on the cycle its run of identical
  // inputs reaches STABLE_CYCLES.
  assign w_same   = ({seg_in, dig_en} == r_prev);
  assign w_accept = w_same && (r_cnt == CNT_ACCEPT);
  assign w_onehot = (dig_en != '0) && ((dig_en & (dig_en - 1'b1)) == '0);
  assign w_multi  = (dig_en != '0) && !w_onehot;
  assign w_cap    = w_accept && w_onehot;

  // Blank is a legal glyph, so only a non-blank bad pattern is an error.
  assign w_err_set  = w_accept && (w_multi || (w_onehot && w_bad && !w_blank));
  assign w_out_free = !r_frame_valid || frame_ready;
  assign w_load     = w_complete && w_out_free;
  assign w_ovr_set  = w_complete && !w_out_free;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SYNC;
    else        r_state <= w_state_next;
  end

  // Next state, got mask and shadow nibbles from the current capture.
  always_comb begin
    w_state_next  = r_state;
    w_got_next    = r_got;
    w_shadow_next = r_shadow;
    w_complete    = 1'b0;
    case (r_state)
      SYNC: begin
        if (w_cap && dig_en[0]) begin
          w_state_next          = SCAN;
          w_got_next            = dig_en;
          w_shadow_next[3:0]    = w_bcd;
        end
      end
      SCAN: begin
        if (w_cap) begin
          // Digit 0 always restarts the frame; others add or overwrite.
          w_got_next = dig_en[0] ? dig_en : (r_got | dig_en);
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_en[k]) w_shadow_next[4*k +: 4] = w_bcd;
          end
          if (&w_got_next) begin
            w_complete   = 1'b1;
            w_got_next   = '0;
            w_state_next = SYNC;
          end
        end
      end
      default: w_state_next = SYNC;
    endcase
  end

  // Stability filter, frame assembly, output handshake and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev        <= '0;
      r_cnt         <= '0;
      r_got         <= '0;
      r_shadow      <= '0;
      r_frame_valid <= 1'b0;
      r_bcd_out     <= '0;
      r_err         <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_prev <= {seg_in, dig_en};
      if (!w_same)              r_cnt <= CW'(1);
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);

      r_got    <= w_got_next;
      r_shadow <= w_shadow_next;

      if (w_load) begin
        r_bcd_out     <= w_shadow_next;
        r_frame_valid <= 1'b1;
      end else if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end

      r_err     <= err_clr ? 1'b0 : (r_err | w_err_set);
      r_overrun <= err_clr ? 1'b0 : (r_overrun | w_ovr_set);
    end
  end

  assign frame_valid = r_frame_valid;
  assign bcd_out     = r_bcd_out;
  assign err         = r_err;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sevtobcd_scan.sv
// Bench for sevtobcd_scan: directed scenarios with literal expectations plus
// randomized bus traffic, all checked every cycle against a reference model.
module tb_sevtobcd_scan;

  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_in = '0;
  logic [ND-1:0] dig_en = '0;
  logic          frame_ready = 1'b1;
  logic          err_clr = 1'b0;
  logic          frame_valid;
  logic [4*ND-1:0] bcd_out;
  logic          err;
  logic          overrun;
  logic          dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sevtobcd_scan #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .frame_ready (frame_ready),
    .err_clr     (err_clr),
    .frame_valid (frame_valid),
    .bcd_out     (bcd_out),
    .err         (err),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011};

  logic [6+ND:0] m_prev;
  int            m_run;
  bit            m_scan;
  bit            m_got [ND];
  logic [3:0]    m_sh  [ND];
  logic          m_fv;
  logic [4*ND-1:0] m_bcd;
  logic          m_err, m_ovr;

  function automatic logic [3:0] decode(input logic [6:0] s);
    if (s == 7'b0) return 4'hA;
    for (int i = 0; i < 10; i++) if (glyph[i] == s) return 4'(i);
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 0; m_scan = 0;
    for (int i = 0; i < ND; i++) begin m_got[i] = 0; m_sh[i] = 4'h0; end
    m_fv = 0; m_bcd = '0; m_err = 0; m_ovr = 0;
  endtask

  // Advance by one clock edge using the inputs present now.
  task automatic model_step();
    logic [6+ND:0] cur;
    logic [3:0] nib;
    int ones, k;
    bit accept, err_set, ovr_set, all_got, free;
    cur = {seg_in, dig_en};
    if (cur == m_prev) m_run++; else m_run = 1;
    m_prev  = cur;
    accept  = (m_run == S);
    ones    = $countones(dig_en);
    k       = 0;
    for (int i = 0; i < ND; i++) if (dig_en[i]) k = i;
    nib     = decode(seg_in);
    err_set = accept && (ones > 1 || (ones == 1 && nib == 4'hF));
    ovr_set = 0;
    free    = !m_fv || frame_ready;
    all_got = 0;
    if (accept && ones == 1) begin
      if (k == 0) begin
        for (int i = 0; i < ND; i++) m_got[i] = 0;
        m_got[0] = 1; m_sh[0] = nib; m_scan = 1;
      end else if (m_scan) begin
        m_got[k] = 1; m_sh[k] = nib;
      end
      all_got = m_scan;
      for (int i = 0; i < ND; i++) if (!m_got[i]) all_got = 0;
    end
    if (all_got) begin
      m_scan = 0;
      for (int i = 0; i < ND; i++) m_got[i] = 0;
      if (free) begin
        m_fv = 1;
        for (int i = 0; i < ND; i++) m_bcd[4*i +: 4] = m_sh[i];
      end else begin
        ovr_set = 1;
      end
    end else if (m_fv && frame_ready) begin
      m_fv = 0;
    end
    m_err = err_clr ? 1'b0 : (m_err | err_set);
    m_ovr = err_clr ? 1'b0 : (m_ovr | ovr_set);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compare process: every falling edge, check outputs then advance model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      check("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
      check("cyc_bcd_out",     32'(bcd_out),     32'(m_bcd));
      check("cyc_err",         32'(err),         32'(m_err));
      check("cyc_overrun",     32'(overrun),     32'(m_ovr));
      check("cyc_state",       32'(dbg_state),   32'(m_scan));
      if (rst_n) model_step();
    end
  end

  // ---------------- driver tasks ----------------
  // Entered and left at 1 time unit after a rising edge.
  task automatic show(input logic [6:0] s, input logic [ND-1:0] d, input int n);
    seg_in = s;
    dig_en = d;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full 0..3 scan showing nibble k of vals on digit k, n cycles each (n>=5);
  // checks the frame visible exactly 4 cycles after digit 3 appears.
  task automatic scan_frame(input logic [15:0] vals, input int n, input logic [15:0] exp,
                            input string name);
    logic [15:0] v;
    v = vals;
    for (int k = 0; k < ND - 1; k++) show(glyph[v[4*k +: 4]], ND'(1) << k, n);
    show(glyph[v[15:12]], 4'b1000, S - 1);
    check({name, "_pre_valid"}, 32'(frame_valid), 32'(frame_ready ? 1'b0 : frame_valid));
    show(glyph[v[15:12]], 4'b1000, 1);
    check({name, "_valid"}, 32'(frame_valid), 32'd1);
    check({name, "_bcd"},   32'(bcd_out),     32'(exp));
    show(glyph[v[15:12]], 4'b1000, n - S);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [6:0] s;
    logic [ND-1:0] d;
    int r, v, k;
    logic [15:0] held;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   32'(frame_valid), 32'd0);
    check("rst_bcd",     32'(bcd_out),     32'd0);
    check("rst_err",     32'(err),         32'd0);
    check("rst_overrun", 32'(overrun),     32'd0);
    check("rst_state",   32'(dbg_state),   32'd0);
    rst_n = 1'b1;
    show(7'b0, 4'b0000, 3);

    // Basic scan 1,2,4,9 with ready high: one-cycle valid.
    frame_ready = 1'b1;
    scan_frame(16'h9421, 6, 16'h9421, "basic");
    check("basic_one_cycle", 32'(frame_valid), 32'd0);
    check("basic_err", 32'(err), 32'd0);

    // Digits held 3 cycles: never captured.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < ND; j++) show(glyph[j + 3], ND'(1) << j, 3);
    check("short_no_valid", 32'(frame_valid), 32'd0);
    check("short_bcd_kept", 32'(bcd_out), 32'h9421);
    show(7'b0, 4'b0000, 4);

    // Bad glyph on digit 2.
    show(glyph[5], 4'b0001, 6);
    show(glyph[6], 4'b0010, 6);
    show(7'b1010101, 4'b0100, S - 1);
    check("bad_err_before", 32'(err), 32'd0);
    show(7'b1010101, 4'b0100, 1);
    check("bad_err_at_capture", 32'(err), 32'd1);
    show(7'b1010101, 4'b0100, 2);
    show(glyph[7], 4'b1000, S);
    check("bad_valid", 32'(frame_valid), 32'd1);
    check("bad_bcd",   32'(bcd_out),     32'h7F65);
    show(7'b0, 4'b0000, 6);
    check("bad_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    show(7'b0, 4'b0000, 1);
    err_clr = 1'b0;
    check("bad_err_cleared", 32'(err), 32'd0);

    // Scan starting mid-frame at digit 2.
    show(glyph[8], 4'b0100, 6);
    show(glyph[8], 4'b1000, 6);
    check("midstart_no_valid", 32'(frame_valid), 32'd0);
    scan_frame(16'h8703, 6, 16'h8703, "midstart");
    show(7'b0, 4'b0000, 3);

    // Backpressure across two scans.
    frame_ready = 1'b0;
    scan_frame(16'h4321, 6, 16'h4321, "hold1");
    scan_frame(16'h6789, 6, 16'h4321, "hold2");
    check("hold_overrun", 32'(overrun), 32'd1);
    frame_ready = 1'b1;
    check("hold_valid_on_ready", 32'(frame_valid), 32'd1);
    show(7'b0, 4'b0000, 1);
    check("hold_released", 32'(frame_valid), 32'd0);
    check("hold_bcd_kept", 32'(bcd_out), 32'h4321);

    // Reset in the middle of digit 2 (overrun still set, bcd nonzero).
    show(glyph[1], 4'b0001, 6);
    show(glyph[2], 4'b0010, 6);
    show(glyph[3], 4'b0100, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid",   32'(frame_valid), 32'd0);
    check("midrst_bcd",     32'(bcd_out),     32'd0);
    check("midrst_overrun", 32'(overrun),     32'd0);
    check("midrst_err",     32'(err),         32'd0);
    check("midrst_state",   32'(dbg_state),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    show(glyph[3], 4'b0100, 6);
    show(glyph[4], 4'b1000, 6);
    check("midrst_no_frame", 32'(frame_valid), 32'd0);
    scan_frame(16'h8642, 6, 16'h8642, "midrst_fresh");

    // Multi-hot enable sets err.
    show(glyph[1], 4'b0110, 6);
    check("multihot_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    show(7'b0, 4'b0000, 1);
    err_clr = 1'b0;

    // Randomized traffic, checked by the model every cycle.
    k = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      v = $urandom_range(0, 15);
      if (r == 0)      d = '0;
      else if (r == 1) d = 4'b0011 << $urandom_range(0, 2);
      else begin
        if (r == 2) k = $urandom_range(0, ND - 1);
        d = ND'(1) << k;
        k = (k + 1) % ND;
      end
      if (v < 10)       s = glyph[v];
      else if (v == 10) s = 7'b0;
      else if (v == 11) s = 7'($urandom);
      else              s = glyph[$urandom_range(0, 9)];
      frame_ready = ($urandom_range(0, 3) != 0);
      err_clr     = ($urandom_range(0, 24) == 0);
      show(s, d, $urandom_range(2, 7));
    end
    err_clr = 1'b0;
    frame_ready = 1'b1;
    held = bcd_out;
    show(7'b0, 4'b0000, 5);
    check("final_bcd_stable", 32'(bcd_out), 32'(held));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
